fwd_hazard_ctrl: RTL and testbench

//  Forwarding and load-use hazard controller for the EX-stage ALU operand muxes.
//  - Tracks destination-register tags of in-flight instructions in EX, MEM and WB.
//  - Computes operand select codes for the instruction in ID; registers them into
//    the EX stage to drive the operand mux A_sel/B_sel inputs.
//  - Detects load-use hazards, stalls ID for one cycle and inserts a bubble into EX.

---
 rtl/fwd_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage ALU operand muxes.
// Tracks in-flight destination tags and registers operand selects into EX.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_a_pc,
  input  logic             id_b_imm,
  input  logic [4:0]       id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             id_ld_trim,
  output logic [2:0]       ex_A_sel,
  output logic [2:0]       ex_B_sel,
  output logic             stall_id,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       ld_trim;
  } tag_t;

  localparam logic [2:0] SEL_PC    = 3'b000;
  localparam logic [2:0] SEL_D1    = 3'b001;
  localparam logic [2:0] SEL_D2    = 3'b000;
  localparam logic [2:0] SEL_IMM   = 3'b001;
  localparam logic [2:0] SEL_ALU   = 3'b010;
  localparam logic [2:0] SEL_DIN   = 3'b011;
  localparam logic [2:0] SEL_TRIM  = 3'b100;

  tag_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag_s;
  logic [2:0]       a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic [2:0]       a_sel_nxt_s, b_sel_nxt_s;
  logic             bubble_q, bubble_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_use_s;
  logic             advance_s;
  logic             wb_unused;

  function automatic logic prod_match(tag_t t, logic [4:0] rs, logic use_rs);
    return t.valid & t.wen & (t.rd != 5'd0) & (t.rd == rs) & use_rs;
  endfunction

  // WB is never a forwarding source: the register file is write-first.
  function automatic logic [2:0] fwd_sel(tag_t ex, tag_t mem, logic [4:0] rs,
                                         logic use_rs, logic [2:0] dflt);
    if (prod_match(ex, rs, use_rs) && !ex.is_load) begin
      return SEL_ALU;
    end else if (prod_match(mem, rs, use_rs)) begin
      if (mem.is_load && mem.ld_trim) begin
        return SEL_TRIM;
      end else begin
        return SEL_DIN;
      end
    end else begin
      return dflt;
    end
  endfunction

  assign id_tag_s = '{valid: 1'b1, rd: id_rd, wen: id_wen,
                      is_load: id_is_load, ld_trim: id_ld_trim};

  assign ld_use_s = ex_q.is_load &
                    ((prod_match(ex_q, id_rs1, id_use_rs1) & !id_a_pc) |
                     (prod_match(ex_q, id_rs2, id_use_rs2) & !id_b_imm));

  assign stall_id  = id_valid & !flush & ld_use_s;
  assign advance_s = id_valid & !stall_id & !flush;

  assign a_sel_nxt_s = id_a_pc  ? SEL_PC  : fwd_sel(ex_q, mem_q, id_rs1, id_use_rs1, SEL_D1);
  assign b_sel_nxt_s = id_b_imm ? SEL_IMM : fwd_sel(ex_q, mem_q, id_rs2, id_use_rs2, SEL_D2);

  assign wb_unused = ^wb_q;

  // Next-state: advance the tag pipeline unless frozen by hold.
  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    a_sel_d  = a_sel_q;
    b_sel_d  = b_sel_q;
    bubble_d = bubble_q;
    cnt_d    = cnt_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (advance_s) begin
        ex_d     = id_tag_s;
        a_sel_d  = a_sel_nxt_s;
        b_sel_d  = b_sel_nxt_s;
        bubble_d = 1'b0;
      end else begin
        ex_d     = '0;
        a_sel_d  = SEL_D1;
        b_sel_d  = SEL_D2;
        bubble_d = 1'b1;
      end
      if (stall_id && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      a_sel_q  <= SEL_D1;
      b_sel_q  <= SEL_D2;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_A_sel  = a_sel_q;
  assign ex_B_sel  = b_sel_q;
  assign ex_bubble = bubble_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; small counter width to reach saturation.
module tb_fwd_hazard_ctrl;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n, hold, flush;
  logic         id_valid, id_use_rs1, id_use_rs2, id_a_pc, id_b_imm;
  logic         id_wen, id_is_load, id_ld_trim;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic [2:0]   ex_A_sel, ex_B_sel;
  logic         stall_id, ex_bubble;
  logic [W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt;

  fwd_hazard_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_rd(id_rd),
    .id_wen(id_wen), .id_is_load(id_is_load), .id_ld_trim(id_ld_trim),
    .ex_A_sel(ex_A_sel), .ex_B_sel(ex_B_sel), .stall_id(stall_id),
    .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ALU op: rd <= rs1 op rs2
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_a_pc = 1'b0; id_b_imm = 1'b0; id_rd = rd; id_wen = 1'b1;
    id_is_load = 1'b0; id_ld_trim = 1'b0;
  endtask

  // Load: rd <= mem[rs1 + imm]
  task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic trim);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
    id_a_pc = 1'b0; id_b_imm = 1'b1; id_rd = rd; id_wen = 1'b1;
    id_is_load = 1'b1; id_ld_trim = trim;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_a_pc = 1'b0; id_b_imm = 1'b0; id_rd = 5'd0; id_wen = 1'b0;
    id_is_load = 1'b0; id_ld_trim = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    nop();
    // 1 reset, with hold and flush asserted to show reset dominates
    hold = 1'b1; flush = 1'b1;
    do_reset();
    hold = 1'b0; flush = 1'b0;
    chk("rst_a", {5'd0, ex_A_sel}, 8'h01);
    chk("rst_b", {5'd0, ex_B_sel}, 8'h00);
    chk("rst_bubble", {7'd0, ex_bubble}, 8'h01);
    chk("rst_cnt", {5'd0, stall_cnt}, 8'h00);

    // 2 add x5,x1,x2 ; sub x6,x5,x5 -> both operands from alu_forward
    alu(5'd5, 5'd1, 5'd2);
    #1 chk("alu_stall0", {7'd0, stall_id}, 8'h00);
    tick();
    chk("alu_first_a", {5'd0, ex_A_sel}, 8'h01);
    chk("alu_first_bubble", {7'd0, ex_bubble}, 8'h00);
    alu(5'd6, 5'd5, 5'd5);
    #1 chk("alu_stall1", {7'd0, stall_id}, 8'h00);
    tick();
    chk("alu_fwd_a", {5'd0, ex_A_sel}, 8'h02);
    chk("alu_fwd_b", {5'd0, ex_B_sel}, 8'h02);

    // 3 lw x7 ; add x8,x7,x1 -> one stall, then din on A
    load(5'd7, 5'd1, 1'b0);
    tick();
    alu(5'd8, 5'd7, 5'd1);
    #1 chk("lu_stall", {7'd0, stall_id}, 8'h01);
    tick();
    chk("lu_bubble", {7'd0, ex_bubble}, 8'h01);
    chk("lu_bub_a", {5'd0, ex_A_sel}, 8'h01);
    chk("lu_cnt", {5'd0, stall_cnt}, 8'h01);
    chk("lu_stall_gone", {7'd0, stall_id}, 8'h00);
    tick();
    chk("lu_a_din", {5'd0, ex_A_sel}, 8'h03);
    chk("lu_b_d2", {5'd0, ex_B_sel}, 8'h00);
    chk("lu_nobubble", {7'd0, ex_bubble}, 8'h00);
    chk("lu_cnt_hold", {5'd0, stall_cnt}, 8'h01);

    // 4 lb x7 ; nop ; add x8,x1,x7 -> trim_forward on B
    load(5'd7, 5'd1, 1'b1);
    tick();
    nop();
    tick();
    alu(5'd8, 5'd1, 5'd7);
    #1 chk("lb_stall0", {7'd0, stall_id}, 8'h00);
    tick();
    chk("lb_b_trim", {5'd0, ex_B_sel}, 8'h04);
    chk("lb_a_d1", {5'd0, ex_A_sel}, 8'h01);
    load(5'd7, 5'd1, 1'b0);
    tick();
    nop();
    tick();
    alu(5'd8, 5'd1, 5'd7);
    tick();
    chk("lw_b_din", {5'd0, ex_B_sel}, 8'h03);
    alu(5'd0, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    alu(5'd8, 5'd1, 5'd0);
    tick();
    chk("x0_b_d2", {5'd0, ex_B_sel}, 8'h00);

    // 5 load-use with flush in the hazard cycle
    do_reset();
    load(5'd7, 5'd1, 1'b0);
    tick();
    alu(5'd8, 5'd7, 5'd1);
    flush = 1'b1;
    #1 chk("fl_stall0", {7'd0, stall_id}, 8'h00);
    tick();
    flush = 1'b0;
    chk("fl_bubble", {7'd0, ex_bubble}, 8'h01);
    chk("fl_cnt", {5'd0, stall_cnt}, 8'h00);
    chk("fl_a", {5'd0, ex_A_sel}, 8'h01);

    // 6 hold for three cycles during a load-use
    nop();
    tick();
    load(5'd7, 5'd1, 1'b0);
    tick();
    alu(5'd8, 5'd7, 5'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hd_stall", {7'd0, stall_id}, 8'h01);
      tick();
      chk("hd_a", {5'd0, ex_A_sel}, 8'h01);
      chk("hd_b", {5'd0, ex_B_sel}, 8'h01);
      chk("hd_bubble", {7'd0, ex_bubble}, 8'h00);
      chk("hd_cnt", {5'd0, stall_cnt}, 8'h00);
    end
    hold = 1'b0;
    #1 chk("hd_rel_stall", {7'd0, stall_id}, 8'h01);
    tick();
    chk("hd_rel_bubble", {7'd0, ex_bubble}, 8'h01);
    chk("hd_rel_cnt", {5'd0, stall_cnt}, 8'h01);
    chk("hd_rel_b", {5'd0, ex_B_sel}, 8'h00);
    tick();
    chk("hd_rel_a_din", {5'd0, ex_A_sel}, 8'h03);

    // Counter saturates at all-ones (7 for a 3-bit counter)
    exp_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      load(5'd7, 5'd1, 1'b0);
      tick();
      alu(5'd8, 5'd7, 5'd1);
      tick();
      tick();
      exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
      chk("sat_cnt", {5'd0, stall_cnt}, exp_cnt[7:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
